// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_CLIENTS requesters; grant and response
// routing are combinational, read ownership is tracked in an in-order tag FIFO.
module mem_access_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter logic [NUM_CLIENTS-1:0] WRITE_MASK = 3'b100
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]     client_start_addr,
  input  logic [NUM_CLIENTS-1:0]                client_req,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]     client_wdata,
  output logic [NUM_CLIENTS-1:0]                client_ack,
  output logic [DATA_WIDTH-1:0]                 client_rdata,
  output logic [NUM_CLIENTS-1:0]                client_rvalid,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_write_data,
  output logic                                  mem_read_valid,
  output logic                                  mem_write_valid,
  input  logic [DATA_WIDTH-1:0]                 mem_data,
  input  logic                                  mem_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_count,
  output logic                                  resp_error
);
  localparam int CW   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int PW   = $clog2(MAX_OUTSTANDING);
  localparam int CNTW = $clog2(MAX_OUTSTANDING+1);

  logic [CW-1:0]          last_grant;
  logic [CW-1:0]          grant_idx;
  logic                   grant_vld;
  logic                   grant_wr;
  logic [NUM_CLIENTS-1:0] elig;
  logic [ADDR_WIDTH-1:0]  addr_q [NUM_CLIENTS];
  logic [CW-1:0]          tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic                   tracker_full;
  logic                   tracker_empty;
  logic                   push;
  logic                   pop;
  logic                   orphan;
  int                     idx;

  assign tracker_empty = (outstanding_count == '0);
  assign tracker_full  = (outstanding_count == CNTW'(MAX_OUTSTANDING));
  // Fullness is judged on the registered count, so a same-cycle pop cannot unblock a reader.
  assign elig = client_req & (WRITE_MASK | {NUM_CLIENTS{~tracker_full}}) & {NUM_CLIENTS{~start}};

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      idx = (int'(last_grant) + k) % NUM_CLIENTS;
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx[CW-1:0];
      end
    end
  end

  assign grant_wr = WRITE_MASK[grant_idx];

  always_comb begin
    client_ack      = '0;
    mem_addr        = '0;
    mem_read_valid  = 1'b0;
    mem_write_valid = 1'b0;
    mem_write_data  = '0;
    if (grant_vld) begin
      client_ack[grant_idx] = 1'b1;
      mem_addr              = addr_q[grant_idx];
      mem_read_valid        = ~grant_wr;
      mem_write_valid       = grant_wr;
      if (grant_wr)
        mem_write_data = client_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign push   = mem_read_valid;
  assign pop    = mem_valid & ~start & ~tracker_empty;
  assign orphan = mem_valid & ~start & tracker_empty;

  assign client_rdata = mem_data;

  always_comb begin
    client_rvalid = '0;
    if (pop)
      client_rvalid[tag_mem[rd_ptr]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant        <= CW'(NUM_CLIENTS-1);
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      outstanding_count <= '0;
      resp_error        <= 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++)
        addr_q[i] <= '0;
    end else if (start) begin
      last_grant        <= CW'(NUM_CLIENTS-1);
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      outstanding_count <= '0;
      resp_error        <= 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++)
        addr_q[i] <= client_start_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin
      if (grant_vld) begin
        last_grant        <= grant_idx;
        addr_q[grant_idx] <= addr_q[grant_idx] + 1'b1;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        outstanding_count <= outstanding_count + 1'b1;
      else if (pop && !push)
        outstanding_count <= outstanding_count - 1'b1;
      if (orphan)
        resp_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed vector table, hand-written corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_mem_access_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MO = 16;
  localparam logic [N-1:0] WM = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [N*AW-1:0] client_start_addr = '0;
  logic [N-1:0] client_req = '0;
  logic [N*DW-1:0] client_wdata = '0;
  logic [N-1:0] client_ack;
  logic [DW-1:0] client_rdata;
  logic [N-1:0] client_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic mem_read_valid, mem_write_valid;
  logic [DW-1:0] mem_data = '0;
  logic mem_valid = 1'b0;
  logic [4:0] outstanding_count;
  logic resp_error;

  mem_access_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                       .MAX_OUTSTANDING(MO), .WRITE_MASK(WM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .client_start_addr(client_start_addr),
    .client_req(client_req), .client_wdata(client_wdata), .client_ack(client_ack),
    .client_rdata(client_rdata), .client_rvalid(client_rvalid), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_valid(mem_read_valid),
    .mem_write_valid(mem_write_valid), .mem_data(mem_data), .mem_valid(mem_valid),
    .outstanding_count(outstanding_count), .resp_error(resp_error));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owners of outstanding reads in issue order, per-client next address.
  int         m_q[$];
  logic [AW-1:0] m_addr[N];
  int         m_last;
  bit         m_err;
  int         pushes;

  typedef struct {
    logic       start;
    logic [2:0] req;
    logic       mv;
    logic [2:0] ack;
    logic [2:0] rvalid;
    logic [15:0] addr;
    logic       rd;
    logic [4:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < N; i++) m_addr[i] = '0;
    m_last = N - 1;
    m_err = 1'b0;
  endtask

  task automatic model_grant(output bit gv, output int g);
    gv = 1'b0;
    g = 0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (!gv && client_req[i] && (WM[i] || m_q.size() < MO) && !start) begin
        gv = 1'b1;
        g = i;
      end
    end
  endtask

  task automatic model_check();
    bit gv;
    int g;
    logic [N-1:0] e_ack, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic e_rd, e_wr;
    model_grant(gv, g);
    e_ack = '0; e_rv = '0; e_addr = '0; e_wd = '0; e_rd = 1'b0; e_wr = 1'b0;
    if (gv) begin
      e_ack[g] = 1'b1;
      e_addr = m_addr[g];
      e_rd = !WM[g];
      e_wr = WM[g];
      if (WM[g]) e_wd = client_wdata[g*DW +: DW];
    end
    if (mem_valid && !start && m_q.size() > 0) e_rv[m_q[0]] = 1'b1;
    chk("ack", 64'(client_ack), 64'(e_ack));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("rd_wr_valid", 64'({mem_read_valid, mem_write_valid}), 64'({e_rd, e_wr}));
    chk("wdata", 64'(mem_write_data), 64'(e_wd));
    chk("rvalid", 64'(client_rvalid), 64'(e_rv));
    chk("rdata", 64'(client_rdata), 64'(mem_data));
    chk("count", 64'(outstanding_count), 64'(m_q.size()));
    chk("resp_error", 64'(resp_error), 64'(m_err));
  endtask

  task automatic model_update();
    bit gv;
    int g;
    model_grant(gv, g);
    if (start) begin
      m_q.delete();
      m_err = 1'b0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) m_addr[i] = client_start_addr[i*AW +: AW];
    end else begin
      if (mem_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (gv) begin
        m_last = g;
        m_addr[g] = m_addr[g] + 1'b1;
        if (!WM[g]) begin
          m_q.push_back(g);
          pushes++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] r, input logic mv);
    start = s;
    client_req = r;
    mem_valid = mv;
    mem_data = $urandom;
  endtask

  task automatic add(input logic s, input logic [2:0] r, input logic mv, input logic [2:0] a,
                     input logic [2:0] rv, input logic [15:0] ad, input logic rd, input logic [4:0] c);
    vec_t v;
    v.start = s; v.req = r; v.mv = mv; v.ack = a; v.rvalid = rv; v.addr = ad; v.rd = rd; v.cnt = c;
    vecs.push_back(v);
  endtask

  initial begin
    model_reset();
    pushes = 0;
    client_start_addr = {16'h0200, 16'h0100, 16'h0000};
    client_wdata = {32'hCAFE_0002, 32'h1111_0001, 32'h2222_0000};
    #12 rst_n = 1'b1;
    #1;

    // start, client 1 alone, its three returns
    add(1, 3'b000, 0, 3'b000, 3'b000, 16'h000, 0, 0);
    add(0, 3'b010, 0, 3'b010, 3'b000, 16'h100, 1, 0);
    add(0, 3'b010, 0, 3'b010, 3'b000, 16'h101, 1, 1);
    add(0, 3'b010, 0, 3'b010, 3'b000, 16'h102, 1, 2);
    add(0, 3'b000, 1, 3'b000, 3'b010, 16'h000, 0, 3);
    add(0, 3'b000, 1, 3'b000, 3'b010, 16'h000, 0, 2);
    add(0, 3'b000, 1, 3'b000, 3'b010, 16'h000, 0, 1);
    add(0, 3'b000, 0, 3'b000, 3'b000, 16'h000, 0, 0);
    // interleaved returns 0,1,0
    add(0, 3'b001, 0, 3'b001, 3'b000, 16'h000, 1, 0);
    add(0, 3'b010, 0, 3'b010, 3'b000, 16'h103, 1, 1);
    add(0, 3'b001, 0, 3'b001, 3'b000, 16'h001, 1, 2);
    add(0, 3'b000, 1, 3'b000, 3'b001, 16'h000, 0, 3);
    add(0, 3'b000, 1, 3'b000, 3'b010, 16'h000, 0, 2);
    add(0, 3'b000, 1, 3'b000, 3'b001, 16'h000, 0, 1);
    add(0, 3'b000, 0, 3'b000, 3'b000, 16'h000, 0, 0);
    // full contention after restart
    add(1, 3'b111, 0, 3'b000, 3'b000, 16'h000, 0, 0);
    add(0, 3'b111, 0, 3'b001, 3'b000, 16'h000, 1, 0);
    add(0, 3'b111, 0, 3'b010, 3'b000, 16'h100, 1, 1);
    add(0, 3'b111, 0, 3'b100, 3'b000, 16'h200, 0, 2);
    add(0, 3'b111, 0, 3'b001, 3'b000, 16'h001, 1, 2);
    add(0, 3'b111, 0, 3'b010, 3'b000, 16'h101, 1, 3);
    add(0, 3'b111, 0, 3'b100, 3'b000, 16'h201, 0, 4);
    add(0, 3'b000, 0, 3'b000, 3'b000, 16'h000, 0, 4);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].req, vecs[i].mv);
      if (i == 16) pushes = 0;
      @(negedge clk);
      chk($sformatf("vec%0d_ack", i), 64'(client_ack), 64'(vecs[i].ack));
      chk($sformatf("vec%0d_rvalid", i), 64'(client_rvalid), 64'(vecs[i].rvalid));
      chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_rd", i), 64'(mem_read_valid), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_cnt", i), 64'(outstanding_count), 64'(vecs[i].cnt));
      if (vecs[i].ack == 3'b100)
        chk($sformatf("vec%0d_wr", i), 64'({mem_write_valid, mem_write_data}), {31'd0, 1'b1, 32'hCAFE_0002});
      model_check();
      @(posedge clk);
      model_update();
      #1;
    end
    chk("contention_pushes", 64'(pushes), 64'd4);

    // tracker full: 16 reads from client 0, then writes still pass
    drive(1, 3'b000, 0); tick();
    for (int i = 0; i < MO; i++) begin drive(0, 3'b001, 0); tick(); end
    drive(0, 3'b101, 0);
    @(negedge clk);
    chk("full_write_ack", 64'(client_ack), 64'b100);
    chk("full_count", 64'(outstanding_count), 64'd16);
    @(posedge clk); model_update(); #1;
    drive(0, 3'b001, 1);
    @(negedge clk);
    chk("full_pop_no_ack", 64'(client_ack), 64'b000);
    chk("full_pop_rvalid", 64'(client_rvalid), 64'b001);
    @(posedge clk); model_update(); #1;
    drive(0, 3'b001, 0);
    @(negedge clk);
    chk("after_pop_ack", 64'(client_ack), 64'b001);
    @(posedge clk); model_update(); #1;

    // address wrap and orphan response
    client_start_addr = {16'h0200, 16'h0100, 16'hFFFF};
    drive(1, 3'b000, 0); tick();
    drive(0, 3'b001, 0);
    @(negedge clk); chk("wrap_addr0", 64'(mem_addr), 64'hFFFF);
    @(posedge clk); model_update(); #1;
    @(negedge clk); chk("wrap_addr1", 64'(mem_addr), 64'h0000);
    @(posedge clk); model_update(); #1;
    drive(0, 3'b000, 1); tick(); tick(); tick();
    drive(0, 3'b000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("orphan_sticky", 64'(resp_error), 64'd1);
      @(posedge clk); model_update(); #1;
    end
    drive(1, 3'b000, 0); tick();
    drive(0, 3'b000, 0);
    @(negedge clk); chk("start_clears_err", 64'(resp_error), 64'd0);
    @(posedge clk); model_update(); #1;

    // start mid-flight
    for (int i = 0; i < 5; i++) begin drive(0, 3'b011, 0); tick(); end
    client_start_addr = {16'h0A00, 16'h0B00, 16'h0C00};
    drive(1, 3'b111, 1);
    @(negedge clk);
    chk("midstart_no_ack", 64'(client_ack), 64'd0);
    chk("midstart_no_rvalid", 64'(client_rvalid), 64'd0);
    chk("midstart_count_before", 64'(outstanding_count), 64'd5);
    @(posedge clk); model_update(); #1;
    drive(0, 3'b111, 0);
    @(negedge clk);
    chk("midstart_ack0", 64'(client_ack), 64'b001);
    chk("midstart_addr", 64'(mem_addr), 64'h0C00);
    chk("midstart_count", 64'(outstanding_count), 64'd0);
    chk("midstart_err", 64'(resp_error), 64'd0);
    @(posedge clk); model_update(); #1;

    // async reset with reads in flight, later return is an orphan
    drive(0, 3'b001, 0); tick(); tick();
    drive(0, 3'b000, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_count", 64'(outstanding_count), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(0, 3'b000, 1); tick();
    drive(0, 3'b000, 0);
    @(negedge clk); chk("rst_orphan_err", 64'(resp_error), 64'd1);
    @(posedge clk); model_update(); #1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0)
        client_start_addr = {16'($urandom), 16'($urandom), 16'($urandom)};
      client_wdata = {32'($urandom), 32'($urandom), 32'($urandom)};
      drive(($urandom_range(0, 39) == 0), 3'($urandom), ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
